// File: rtl/rst_sequencer.sv
// Staged reset controller: power-on hold, debounced button, software request,
// and in-order release of NumRst active-low resets. Reports the last reset cause.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_HOLD   | all resets asserted; counting clean cycles after last trigger
// ST_RELEASE| releasing rst_n_o one bit every StageGap cycles
// ST_RUN    | all resets released; waiting for a trigger
module rst_sequencer #(
  parameter int NumRst         = 3,
  parameter int HoldCycles     = 195,
  parameter int StageGap       = 16,
  parameter int DebounceCycles = 1000
) (
  input  logic              clk_sys_i,
  input  logic              rst_sys_i,
  input  logic              ext_rst_ni,
  input  logic              sw_rst_req_i,
  output logic [NumRst-1:0] rst_n_o,
  output logic              seq_done_o,
  output logic [1:0]        rst_cause_o
);

  localparam int MaxHg  = (HoldCycles > StageGap) ? HoldCycles : StageGap;
  localparam int MaxCyc = (MaxHg > DebounceCycles) ? MaxHg : DebounceCycles;
  localparam int CW     = $clog2(MaxCyc + 1);
  localparam int SW     = (NumRst > 1) ? $clog2(NumRst) : 1;

  localparam logic [1:0] CausePor = 2'b00;
  localparam logic [1:0] CauseBtn = 2'b01;
  localparam logic [1:0] CauseSw  = 2'b10;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [NumRst-1:0] rst_n_q, rst_n_d;
  logic              done_q, done_d;
  logic [1:0]        cause_q, cause_d;

  logic              sync1_q, sync2_q;
  logic              btn_d_q, btn_d_d;
  logic [CW-1:0]     db_cnt_q, db_cnt_d;

  logic              btn_trig;
  logic              trig;
  logic [1:0]        trig_cause;

  // Debounce: the filtered level follows the synchronised button only after a
  // full run of DebounceCycles disagreeing samples.
  always_comb begin
    btn_d_d  = btn_d_q;
    db_cnt_d = '0;
    if (sync2_q != btn_d_q) begin
      if (db_cnt_q == CW'(DebounceCycles - 1)) begin
        btn_d_d  = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign btn_trig   = ~btn_d_q;
  assign trig       = btn_trig | sw_rst_req_i;
  assign trig_cause = btn_trig ? CauseBtn : CauseSw;

  // Sequencer next state: any trigger restarts the hold, otherwise count and
  // release one bit per stage.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_HOLD: begin
        rst_n_d = '0;
        done_d  = 1'b0;
        if (trig) begin
          cnt_d   = '0;
          cause_d = trig_cause;
        end else if (cnt_q == CW'(HoldCycles - 1)) begin
          cnt_d      = '0;
          rst_n_d[0] = 1'b1;
          if (NumRst == 1) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
            stage_d = SW'(1);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE, ST_RUN: begin
        if (trig) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          stage_d = '0;
          rst_n_d = '0;
          done_d  = 1'b0;
          cause_d = trig_cause;
        end else if (state_q == ST_RELEASE) begin
          if (cnt_q == CW'(StageGap - 1)) begin
            cnt_d = '0;
            for (int k = 0; k < NumRst; k++) begin
              if (stage_q == SW'(k)) rst_n_d[k] = 1'b1;
            end
            // Stop stepping on the last bit so the stage index never wraps.
            if (stage_q == SW'(NumRst - 1)) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              stage_d = stage_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
        stage_d = '0;
        rst_n_d = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  // All state, including the button synchroniser, with synchronous reset.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state_q  <= ST_HOLD;
      cnt_q    <= '0;
      stage_q  <= '0;
      rst_n_q  <= '0;
      done_q   <= 1'b0;
      cause_q  <= CausePor;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      btn_d_q  <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      rst_n_q  <= rst_n_d;
      done_q   <= done_d;
      cause_q  <= cause_d;
      sync1_q  <= ext_rst_ni;
      sync2_q  <= sync1_q;
      btn_d_q  <= btn_d_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign rst_n_o     = rst_n_q;
  assign seq_done_o  = done_q;
  assign rst_cause_o = cause_q;

endmodule
